// File: rtl/level_sequencer.sv
// Game-progression controller: counts hits/misses, advances levels, derives the symbol period.
// Optional LEVEL_SKIP_EN adds a skipLevel input that completes the current level's quota.
module level_sequencer #(
  parameter int NUM_LEVELS     = 3,
  parameter int LEVEL_W        = 4,
  parameter int PERIOD_W       = 32,
  parameter int BASE_PERIOD    = 100000000,
  parameter int PERIOD_STEP    = 50000,
  parameter int MIN_PERIOD     = 10000000,
  parameter int HITS_PER_LEVEL = 10,
  parameter int MAX_MISSES     = 3,
  parameter int CNT_W          = 8
) (
  input  logic                Clk100M,
  input  logic                Rst_n,
  input  logic                start,
  input  logic                hit,
  input  logic                miss,
`ifdef LEVEL_SKIP_EN
  input  logic                skipLevel,
`endif
  output logic                newLevel,
  output logic                victory,
  output logic                defeat,
  output logic [LEVEL_W-1:0]  curLevel,
  output logic [PERIOD_W-1:0] symGenMax,
  output logic [CNT_W-1:0]    hitCount,
  output logic [CNT_W-1:0]    missCount
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PLAY    = 2'd1,
    S_VICTORY = 2'd2,
    S_DEFEAT  = 2'd3
  } state_t;

  localparam logic [PERIOD_W-1:0] C_BASE   = PERIOD_W'(BASE_PERIOD);
  localparam logic [PERIOD_W-1:0] C_STEP   = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] C_MIN    = PERIOD_W'(MIN_PERIOD);
  localparam logic [LEVEL_W-1:0]  C_LEVELS = LEVEL_W'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0]  C_LVL1   = LEVEL_W'(1);
  localparam logic [CNT_W-1:0]    C_HITS   = CNT_W'(HITS_PER_LEVEL);
  localparam logic [CNT_W-1:0]    C_MISSES = CNT_W'(MAX_MISSES);

  state_t              r_state, w_state_next;
  logic                r_new_level, w_new_level_next;
  logic                r_victory, w_victory_next;
  logic                r_defeat, w_defeat_next;
  logic [LEVEL_W-1:0]  r_level, w_level_next;
  logic [PERIOD_W-1:0] r_period, w_period_next;
  logic [CNT_W-1:0]    r_hit_cnt, w_hit_cnt_next;
  logic [CNT_W-1:0]    r_miss_cnt, w_miss_cnt_next;

  logic                w_skip;
  logic [CNT_W-1:0]    w_hit_inc;
  logic [CNT_W-1:0]    w_miss_inc;
  logic                w_defeat_now;
  logic                w_level_done;
  logic [PERIOD_W-1:0] w_step;
  logic [PERIOD_W-1:0] w_period_dec;

`ifdef LEVEL_SKIP_EN
  assign w_skip = skipLevel;
`else
  assign w_skip = 1'b0;
`endif

  assign w_hit_inc    = r_hit_cnt + CNT_W'(1);
  assign w_miss_inc   = r_miss_cnt + CNT_W'(1);
  assign w_defeat_now = miss && (w_miss_inc == C_MISSES);
  assign w_level_done = (hit && (w_hit_inc == C_HITS)) || w_skip;

  // Underflow of the subtraction and landing below the floor both saturate to MIN_PERIOD.
  assign w_step       = C_STEP * PERIOD_W'(r_level);
  assign w_period_dec = ((r_period < w_step) || ((r_period - w_step) < C_MIN))
                        ? C_MIN : (r_period - w_step);

  always_comb begin
    w_state_next     = r_state;
    w_new_level_next = 1'b0;
    w_victory_next   = r_victory;
    w_defeat_next    = r_defeat;
    w_level_next     = r_level;
    w_period_next    = r_period;
    w_hit_cnt_next   = r_hit_cnt;
    w_miss_cnt_next  = r_miss_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next     = S_PLAY;
          w_new_level_next = 1'b1;
        end
      end
      S_PLAY: begin
        if (hit)  w_hit_cnt_next  = w_hit_inc;
        if (miss) w_miss_cnt_next = w_miss_inc;
        if (w_defeat_now) begin
          w_state_next  = S_DEFEAT;
          w_defeat_next = 1'b1;
        end else if (w_level_done) begin
          if (r_level < C_LEVELS) begin
            w_level_next     = r_level + C_LVL1;
            w_hit_cnt_next   = '0;
            w_new_level_next = 1'b1;
            w_period_next    = w_period_dec;
          end else begin
            w_state_next   = S_VICTORY;
            w_victory_next = 1'b1;
            w_hit_cnt_next = C_HITS;
          end
        end
      end
      default: begin
        // Terminal states restart straight into play with a fresh game.
        if (start) begin
          w_state_next     = S_PLAY;
          w_new_level_next = 1'b1;
          w_victory_next   = 1'b0;
          w_defeat_next    = 1'b0;
          w_level_next     = C_LVL1;
          w_period_next    = C_BASE;
          w_hit_cnt_next   = '0;
          w_miss_cnt_next  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= S_IDLE;
      r_new_level <= 1'b0;
      r_victory   <= 1'b0;
      r_defeat    <= 1'b0;
      r_level     <= C_LVL1;
      r_period    <= C_BASE;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_new_level <= w_new_level_next;
      r_victory   <= w_victory_next;
      r_defeat    <= w_defeat_next;
      r_level     <= w_level_next;
      r_period    <= w_period_next;
      r_hit_cnt   <= w_hit_cnt_next;
      r_miss_cnt  <= w_miss_cnt_next;
    end
  end

  assign newLevel  = r_new_level;
  assign victory   = r_victory;
  assign defeat    = r_defeat;
  assign curLevel  = r_level;
  assign symGenMax = r_period;
  assign hitCount  = r_hit_cnt;
  assign missCount = r_miss_cnt;

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: default instance plus a floor-saturation instance.
module tb_level_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, hit = 1'b0, miss = 1'b0, skip = 1'b0;
  logic        s_start = 1'b0, s_hit = 1'b0, s_miss = 1'b0, s_skip = 1'b0;

  logic        new_level, vic, def;
  logic [3:0]  level;
  logic [31:0] period;
  logic [7:0]  hcnt, mcnt;

  logic        s_new_level, s_vic, s_def;
  logic [3:0]  s_level;
  logic [31:0] s_period;
  logic [7:0]  s_hcnt, s_mcnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  level_sequencer u_dut (
    .Clk100M(clk), .Rst_n(rst_n), .start(start), .hit(hit), .miss(miss),
`ifdef LEVEL_SKIP_EN
    .skipLevel(skip),
`endif
    .newLevel(new_level), .victory(vic), .defeat(def), .curLevel(level),
    .symGenMax(period), .hitCount(hcnt), .missCount(mcnt)
  );

  level_sequencer #(.MIN_PERIOD(99960000)) u_sat (
    .Clk100M(clk), .Rst_n(rst_n), .start(s_start), .hit(s_hit), .miss(s_miss),
`ifdef LEVEL_SKIP_EN
    .skipLevel(s_skip),
`endif
    .newLevel(s_new_level), .victory(s_vic), .defeat(s_def), .curLevel(s_level),
    .symGenMax(s_period), .hitCount(s_hcnt), .missCount(s_mcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Each pulse is driven for one full cycle starting at a falling edge; the
  // registered response is sampled at the following falling edge.
  task automatic pulse(input bit b_start, input bit b_hit, input bit b_miss, input bit b_skip);
    @(negedge clk);
    start = b_start; hit = b_hit; miss = b_miss; skip = b_skip;
    @(negedge clk);
    start = 1'b0; hit = 1'b0; miss = 1'b0; skip = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    s_skip = 1'b0;
    #23;
    check("rst_newLevel", new_level, 0);
    check("rst_victory", vic, 0);
    check("rst_defeat", def, 0);
    check("rst_curLevel", level, 1);
    check("rst_symGenMax", period, 100000000);
    check("rst_counts", {hcnt, mcnt}, 0);
    @(negedge clk) rst_n = 1'b1;

    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("idle_ignores_hit_miss", {hcnt, mcnt}, 0);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_newLevel", new_level, 1);
    check("start_curLevel", level, 1);
    check("start_symGenMax", period, 100000000);
    @(negedge clk);
    check("start_newLevel_one_cycle", new_level, 0);

    hits(9);
    check("l1_hit9_count", hcnt, 9);
    check("l1_hit9_level", level, 1);
    hits(1);
    check("l2_curLevel", level, 2);
    check("l2_symGenMax", period, 99950000);
    check("l2_hitCount", hcnt, 0);
    check("l2_newLevel", new_level, 1);
    @(negedge clk);
    check("l2_newLevel_one_cycle", new_level, 0);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("l2_miss1", mcnt, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("play_ignores_start", {level, hcnt, mcnt, new_level}, {4'd2, 8'd0, 8'd1, 1'b0});

    hits(10);
    check("l3_curLevel", level, 3);
    check("l3_symGenMax", period, 99850000);
    check("l3_missCount_kept", mcnt, 1);

    hits(10);
    check("victory_flag", vic, 1);
    check("victory_curLevel", level, 3);
    check("victory_symGenMax", period, 99850000);
    check("victory_no_newLevel", new_level, 0);
    check("victory_hitCount", hcnt, 10);
    hits(1);
    check("victory_ignores_hit", hcnt, 10);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_victory_clear", vic, 0);
    check("restart_newLevel", new_level, 1);
    check("restart_state", {level, period}, {4'd1, 32'd100000000});
    check("restart_counts", {hcnt, mcnt}, 0);

    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    hits(10);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("spread_miss2", mcnt, 2);
    check("spread_level2", level, 2);
    check("spread_defeat_low", def, 0);
    hits(9);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("defeat_flag", def, 1);
    check("defeat_curLevel_unchanged", level, 2);
    check("defeat_symGenMax_unchanged", period, 99950000);
    check("defeat_missCount", mcnt, 3);
    check("defeat_hitCount", hcnt, 10);
    check("defeat_no_newLevel", new_level, 0);
    hits(2);
    check("defeat_ignores_hit", hcnt, 10);

    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_defeat_clear", def, 0);
    check("restart_defeat_counts", {hcnt, mcnt}, 0);
    hits(10);
    hits(3);
    check("pre_reset_level2", {level, hcnt}, {4'd2, 8'd3});

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_curLevel", level, 1);
    check("async_rst_symGenMax", period, 100000000);
    check("async_rst_hitCount", hcnt, 0);
    @(negedge clk) rst_n = 1'b1;

    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) s_hit = 1'b1;
      @(negedge clk) s_hit = 1'b0;
    end
    check("sat_curLevel", s_level, 2);
    check("sat_symGenMax_floor", s_period, 99960000);
    check("sat_flags", {s_vic, s_def}, 0);

`ifdef LEVEL_SKIP_EN
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    hits(4);
    check("skip_pre_hitCount", hcnt, 4);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("skip_curLevel", level, 2);
    check("skip_symGenMax", period, 99950000);
    check("skip_hitCount", hcnt, 0);
    check("skip_newLevel", new_level, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Parametrised game-progression controller: tracks correct/missed symbols, advances the level after a programmable hit count, and derives the symbol-generation period for the symbol generator's clock divider.
- Adds to the fixed 3-level controller: configurable level count, period schedule with floor saturation, a defeat condition, and an explicit start handshake.
- Sits between the input/match logic (hit/miss pulses) and the symbol generator and display (level, period, status flags).

Parameters:
- NUM_LEVELS, 3, highest level; reaching its hit quota gives victory
- LEVEL_W, 4, width of curLevel; must satisfy NUM_LEVELS < 2^LEVEL_W
- PERIOD_W, 32, width of symGenMax
- BASE_PERIOD, 100000000, level-1 period in Clk100M cycles (1 s)
- PERIOD_STEP, 50000, per-level decrement multiplier
- MIN_PERIOD, 10000000, floor for symGenMax
- HITS_PER_LEVEL, 10, hits needed to leave a level
- MAX_MISSES, 3, misses that cause defeat
- CNT_W, 8, width of hit/miss counters

Ports:
- Clk100M  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins play from IDLE
- hit  in  1  one-cycle pulse; correct symbol
- miss  in  1  one-cycle pulse; wrong or expired symbol
- newLevel  out  1  one-cycle pulse on game start and on each level advance
- victory  out  1  sticky; high in VICTORY
- defeat  out  1  sticky; high in DEFEAT
- curLevel  out  LEVEL_W  current level, 1-based
- symGenMax  out  PERIOD_W  current symbol period
- hitCount  out  CNT_W  hits in current level
- missCount  out  CNT_W  misses in current game

Behaviour:
- Clock and reset:
  - One clock: Clk100M.
  - Reset is asynchronous and active-low on Rst_n; deassertion is synchronous to Clk100M upstream.
  - While Rst_n=0, all state clears immediately, including during play.
- Reset values:
  - state=IDLE, curLevel=1, symGenMax=BASE_PERIOD.
  - newLevel=0, victory=0, defeat=0, hitCount=0, missCount=0.
- All outputs are registered. Every response appears 1 cycle after the qualifying edge.
- FSM states: IDLE, PLAY, VICTORY, DEFEAT.
- IDLE:
  - hit/miss are ignored.
  - On start: go to PLAY and pulse newLevel for 1 cycle.
  - Counters and level are already at their reset values.
- PLAY, counters:
  - hit: hitCount+1.
  - miss: missCount+1.
  - hit and miss in the same cycle: both counters update.
- PLAY, defeat:
  - If a miss makes missCount reach MAX_MISSES: go to DEFEAT and set defeat=1.
  - Defeat has priority over a simultaneous level advance or victory.
- PLAY, level-up: if a hit makes hitCount reach HITS_PER_LEVEL and there is no defeat:
  - If curLevel < NUM_LEVELS: curLevel+1, hitCount=0, newLevel pulses 1 cycle.
  - symGenMax = max(symGenMax - PERIOD_STEP*curLevel, MIN_PERIOD), using the old curLevel.
  - The product is computed at PERIOD_W width. An underflow (step exceeding symGenMax) also saturates to MIN_PERIOD.
  - missCount is retained across levels.
  - If curLevel == NUM_LEVELS: go to VICTORY and set victory=1. curLevel and symGenMax are unchanged. newLevel is not pulsed. hitCount holds at HITS_PER_LEVEL.
- start while in PLAY is ignored.
- VICTORY / DEFEAT:
  - Terminal; hit/miss are ignored.
  - On start: return to the game-start condition. All counters, level and period take their reset values, state=PLAY, newLevel pulses.
  - victory/defeat clear in the same cycle.
- Counters never wrap in normal use. MAX_MISSES and HITS_PER_LEVEL must both be < 2^CNT_W.
- Width rules:
  - PERIOD_STEP*NUM_LEVELS must fit in PERIOD_W.
  - BASE_PERIOD ≥ MIN_PERIOD ≥ 1.

Optional Feature:
- Macro: LEVEL_SKIP_EN.
- Defined:
  - Adds input port skipLevel (1 bit).
  - A skipLevel pulse in PLAY acts exactly as the hit that completes the current level's quota, including the period update and victory at NUM_LEVELS.
  - skipLevel is ignored when miss-driven defeat occurs the same cycle.
  - skipLevel is ignored outside PLAY.
- Not defined: the port is absent and behaviour is exactly as above.

Test Plan:
- Reset, then start → next cycle: state PLAY, newLevel=1 for exactly 1 cycle, curLevel=1, symGenMax=100000000.
- 10 hits in level 1 → curLevel=2, symGenMax=99950000, hitCount=0, newLevel pulses once.
- 10 more hits → curLevel=3, symGenMax=99850000.
- 10 more hits → victory=1, curLevel stays 3, no newLevel pulse.
- 3 misses spread over levels → defeat=1 after the third. Subsequent hits do not change hitCount.
- Hit completing the quota and the 3rd miss in the same cycle → defeat=1, curLevel unchanged.
- Rst_n low mid-PLAY (level 2) → outputs return to reset values immediately, without waiting for a clock edge.
- MIN_PERIOD=99960000 override, level 1→2 → symGenMax=99960000 (saturated).
- With LEVEL_SKIP_EN defined: skipLevel in level 1 with hitCount=4 → curLevel=2, symGenMax=99950000.
